// File: rtl/cursor_ctrl.sv
// VT52 cursor movement controller: applies decoded cursor commands to a shadow
// position, strobes the clamped result to the cursor block and requests scrolls.
module cursor_ctrl #(
    parameter int ROW_BITS = 5,
    parameter int COL_BITS = 7,
    parameter int ROWS     = 24,
    parameter int COLS     = 80,
    parameter int TAB_STOP = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [3:0]          cmd,
    input  logic [ROW_BITS-1:0] arg_row,
    input  logic [COL_BITS-1:0] arg_col,
    output logic [COL_BITS-1:0] new_x,
    output logic [ROW_BITS-1:0] new_y,
    output logic                wen,
    output logic                scroll_req,
    output logic                scroll_dir,
    input  logic                scroll_ack
);

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_SCROLL = 1'b1;

    localparam logic [3:0] CMD_RIGHT  = 4'd0;
    localparam logic [3:0] CMD_LEFT   = 4'd1;
    localparam logic [3:0] CMD_UP     = 4'd2;
    localparam logic [3:0] CMD_DOWN   = 4'd3;
    localparam logic [3:0] CMD_HOME   = 4'd4;
    localparam logic [3:0] CMD_CR     = 4'd5;
    localparam logic [3:0] CMD_LF     = 4'd6;
    localparam logic [3:0] CMD_RLF    = 4'd7;
    localparam logic [3:0] CMD_TAB    = 4'd8;
    localparam logic [3:0] CMD_DIRECT = 4'd9;

    localparam logic [COL_BITS-1:0] X_MAX   = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS-1:0] Y_MAX   = ROW_BITS'(ROWS - 1);
    localparam logic [COL_BITS-1:0] COL_ONE = COL_BITS'(1);
    localparam logic [ROW_BITS-1:0] ROW_ONE = ROW_BITS'(1);
    // One extra bit so the next tab stop past the last column cannot wrap.
    localparam logic [COL_BITS:0]   TAB_W    = (COL_BITS + 1)'(TAB_STOP);
    localparam logic [COL_BITS:0]   TAB_MASK = ~(TAB_W - (COL_BITS + 1)'(1));

    logic                state_reg;
    logic [COL_BITS-1:0] x_reg, x_next;
    logic [ROW_BITS-1:0] y_reg, y_next;
    logic                wen_reg, wen_next;
    logic                dir_reg, dir_next;
    logic                scroll_next;
    logic [COL_BITS:0]   tab_t;

    assign cmd_ready  = (state_reg == ST_IDLE);
    assign scroll_req = (state_reg == ST_SCROLL);
    assign scroll_dir = dir_reg;
    assign new_x      = x_reg;
    assign new_y      = y_reg;
    assign wen        = wen_reg;

    always_comb begin
        x_next      = x_reg;
        y_next      = y_reg;
        wen_next    = 1'b1;
        dir_next    = dir_reg;
        scroll_next = 1'b0;
        tab_t       = ({1'b0, x_reg} & TAB_MASK) + TAB_W;
        case (cmd)
            CMD_RIGHT:  if (x_reg != X_MAX) x_next = x_reg + COL_ONE;
            CMD_LEFT:   if (x_reg != '0) x_next = x_reg - COL_ONE;
            CMD_UP:     if (y_reg != '0) y_next = y_reg - ROW_ONE;
            CMD_DOWN:   if (y_reg != Y_MAX) y_next = y_reg + ROW_ONE;
            CMD_HOME: begin
                x_next = '0;
                y_next = '0;
            end
            CMD_CR:     x_next = '0;
            CMD_LF: begin
                if (y_reg != Y_MAX) begin
                    y_next = y_reg + ROW_ONE;
                end else begin
                    scroll_next = 1'b1;
                    dir_next    = 1'b0;
                end
            end
            CMD_RLF: begin
                if (y_reg != '0) begin
                    y_next = y_reg - ROW_ONE;
                end else begin
                    scroll_next = 1'b1;
                    dir_next    = 1'b1;
                end
            end
            CMD_TAB: begin
                if (tab_t <= {1'b0, X_MAX}) begin
                    x_next = tab_t[COL_BITS-1:0];
                end else if (x_reg != X_MAX) begin
                    x_next = x_reg + COL_ONE;
                end
            end
            CMD_DIRECT: begin
                if (arg_row <= Y_MAX) y_next = arg_row;
                if (arg_col <= X_MAX) x_next = arg_col;
            end
            default:    wen_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            wen_reg   <= 1'b0;
            dir_reg   <= 1'b0;
        end else begin
            wen_reg <= 1'b0;
            if (state_reg == ST_IDLE) begin
                if (cmd_valid) begin
                    x_reg   <= x_next;
                    y_reg   <= y_next;
                    wen_reg <= wen_next;
                    dir_reg <= dir_next;
                    if (scroll_next) state_reg <= ST_SCROLL;
                end
            end else if (scroll_ack) begin
                state_reg <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_cursor_ctrl.sv
// Bench for cursor_ctrl: directed test-plan sequences plus random commands,
// all compared every cycle against an integer model of the cursor rules.
module tb_cursor_ctrl;

    localparam int ROWS = 24;
    localparam int COLS = 80;
    localparam int TAB_STOP = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd = 4'd0;
    logic [4:0] arg_row = '0;
    logic [6:0] arg_col = '0;
    logic [6:0] new_x;
    logic [4:0] new_y;
    logic       wen;
    logic       scroll_req;
    logic       scroll_dir;
    logic       scroll_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_x = 0;
    int m_y = 0;
    bit m_busy = 0;
    bit m_wen = 0;
    bit m_dir = 0;

    cursor_ctrl #(
        .ROW_BITS(5), .COL_BITS(7), .ROWS(ROWS), .COLS(COLS), .TAB_STOP(TAB_STOP)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .arg_row(arg_row), .arg_col(arg_col), .new_x(new_x),
        .new_y(new_y), .wen(wen), .scroll_req(scroll_req), .scroll_dir(scroll_dir),
        .scroll_ack(scroll_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_apply(input int c, input int r, input int col);
        int t;
        case (c)
            0: m_x = imin(m_x + 1, COLS - 1);
            1: m_x = imax(m_x - 1, 0);
            2: m_y = imax(m_y - 1, 0);
            3: m_y = imin(m_y + 1, ROWS - 1);
            4: begin m_x = 0; m_y = 0; end
            5: m_x = 0;
            6: if (m_y < ROWS - 1) m_y = m_y + 1; else begin m_busy = 1; m_dir = 0; end
            7: if (m_y > 0) m_y = m_y - 1; else begin m_busy = 1; m_dir = 1; end
            8: begin
                t = (m_x / TAB_STOP + 1) * TAB_STOP;
                m_x = (t <= COLS - 1) ? t : imin(m_x + 1, COLS - 1);
            end
            9: begin
                if (r < ROWS) m_y = r;
                if (col < COLS) m_x = col;
            end
            default: ;
        endcase
        m_wen = (c < 10);
    endtask

    task automatic compare_all();
        check("new_x", 32'(new_x), 32'(m_x));
        check("new_y", 32'(new_y), 32'(m_y));
        check("wen", 32'(wen), 32'(m_wen));
        check("scroll_req", 32'(scroll_req), 32'(m_busy));
        check("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
        if (m_busy) check("scroll_dir", 32'(scroll_dir), 32'(m_dir));
    endtask

    // Drive one cycle of inputs, advance past the edge, update model, compare.
    task automatic step(input bit v, input int c, input int r, input int col, input bit a);
        cmd_valid  = v;
        cmd        = 4'(c);
        arg_row    = 5'(r);
        arg_col    = 7'(col);
        scroll_ack = a;
        @(posedge clk);
        #1;
        m_wen = 0;
        if (!m_busy) begin
            if (v) begin
                model_apply(c, r, col);
                $display("cmd %0d row %0d col %0d -> x %0d y %0d busy %0d", c, r, col, m_x, m_y, m_busy);
            end
        end else if (a) begin
            m_busy = 0;
        end
        compare_all();
    endtask

    task automatic async_reset();
        cmd_valid = 0;
        scroll_ack = 0;
        #2;
        reset = 1;
        #1;
        m_x = 0; m_y = 0; m_busy = 0; m_wen = 0; m_dir = 0;
        compare_all();
        check("rst_dir", 32'(scroll_dir), 32'd0);
        @(negedge clk);
        reset = 0;
        #1;
        check("rst_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        #1;
        compare_all();
        check("rst_dir", 32'(scroll_dir), 32'd0);

        // Back-to-back RIGHT
        step(1, 0, 0, 0, 0); check("right1", 32'(new_x), 32'd1);
        step(1, 0, 0, 0, 0); check("right2", 32'(new_x), 32'd2);
        step(1, 0, 0, 0, 0); check("right3", 32'(new_x), 32'd3);
        step(0, 0, 0, 0, 0);

        // Saturation
        step(1, 4, 0, 0, 0);
        step(1, 1, 0, 0, 0); check("left0_wen", 32'(wen), 32'd1);
        step(1, 9, 23, 79, 0);
        step(1, 0, 0, 0, 0); check("right_sat", 32'(new_x), 32'd79);
        step(1, 3, 0, 0, 0); check("down_sat", 32'(new_y), 32'd23);

        // TAB cases
        step(1, 9, 0, 0, 0);  step(1, 8, 0, 0, 0); check("tab0", 32'(new_x), 32'd8);
        step(1, 9, 0, 7, 0);  step(1, 8, 0, 0, 0); check("tab7", 32'(new_x), 32'd8);
        step(1, 8, 0, 0, 0);  check("tab8", 32'(new_x), 32'd16);
        step(1, 9, 0, 72, 0); step(1, 8, 0, 0, 0); check("tab72", 32'(new_x), 32'd73);
        step(1, 9, 0, 79, 0); step(1, 8, 0, 0, 0); check("tab79", 32'(new_x), 32'd79);

        // DIRECT range checks and reserved code
        step(1, 9, 5, 5, 0);
        step(1, 9, 30, 10, 0); check("direct_row", 32'(new_y), 32'd5);
        step(1, 9, 3, 100, 0); check("direct_col", 32'(new_x), 32'd10);
        step(1, 12, 0, 0, 0);  check("reserved_wen", 32'(wen), 32'd0);
        step(0, 0, 0, 0, 0);

        // Scroll up with held command
        step(1, 9, 23, 4, 0);
        step(1, 6, 0, 0, 0);   check("lf_dir", 32'(scroll_dir), 32'd0);
        repeat (5) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);   check("ack_ready", 32'(cmd_ready), 32'd1);
        step(1, 0, 0, 0, 0);   check("held_cmd", 32'(new_x), 32'd5);
        step(0, 0, 0, 0, 0);

        // Scroll down
        step(1, 4, 0, 0, 0);
        step(1, 7, 0, 0, 0);   check("rlf_dir", 32'(scroll_dir), 32'd1);
        repeat (5) step(1, 2, 0, 0, 0);
        step(1, 2, 0, 0, 1);
        step(1, 3, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Minimum round trip: ack in first scroll cycle
        step(1, 9, 23, 0, 0);
        step(1, 6, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // Reset mid-scroll and mid-sequence; stray ack in idle
        step(1, 9, 23, 0, 0);
        step(1, 6, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        async_reset();
        step(1, 9, 12, 40, 0);
        async_reset();
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int c;
            c = (($urandom_range(0, 3) == 0) ? (6 + $urandom_range(0, 1)) : $urandom_range(0, 15));
            step(($urandom_range(0, 9) < 7), c, $urandom_range(0, 31), $urandom_range(0, 127),
                 ($urandom_range(0, 9) < 3));
            if ($urandom_range(0, 99) == 0) async_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cursor_ctrl.md
# cursor_ctrl

Cursor movement controller for the VT52 terminal core. Accepts decoded cursor commands (moves, home, CR, LF, reverse LF, tab, direct address) one at a time over a valid/ready handshake. Keeps a shadow copy of the cursor position and produces the clamped next position plus a one-cycle write strobe for the cursor position/blink block. When a line feed runs off the bottom row, or a reverse line feed runs off the top row, it requests a screen scroll and holds off new commands until the scroll engine acknowledges.

## Interface
- ROW_BITS, 5, width of row coordinate
- COL_BITS, 7, width of column coordinate
- ROWS, 24, number of text rows; legal rows 0..ROWS-1
- COLS, 80, number of text columns; legal columns 0..COLS-1
- TAB_STOP, 8, tab stop spacing (power of two)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd  in  4  command code (see Operation)
- arg_row  in  ROW_BITS  row argument for DIRECT
- arg_col  in  COL_BITS  column argument for DIRECT
- new_x  out  COL_BITS  position column, registered; feeds cursor new_x
- new_y  out  ROW_BITS  position row, registered; feeds cursor new_y
- wen  out  1  one-cycle write strobe to cursor (also restarts blink)
- scroll_req  out  1  scroll request, level, held until acknowledged
- scroll_dir  out  1  0 = scroll up (content moves up), 1 = scroll down; valid while scroll_req
- scroll_ack  in  1  scroll engine done; sampled only while scroll_req=1

## Operation
- Two states: IDLE and SCROLL. cmd_ready = (state == IDLE), combinational from the state register.
- A command is accepted on a rising edge with cmd_valid=1 and cmd_ready=1. All arithmetic uses the current shadow position (new_x, new_y). Results saturate and never leave the legal range.
- Command codes:
  - 0 RIGHT: x = min(x+1, COLS-1)
  - 1 LEFT/BS: x = max(x-1, 0)
  - 2 UP: y = max(y-1, 0)
  - 3 DOWN: y = min(y+1, ROWS-1)
  - 4 HOME: x=0, y=0
  - 5 CR: x=0
  - 6 LF: if y < ROWS-1 then y+1; else y unchanged, enter SCROLL with scroll_dir=0
  - 7 RLF: if y > 0 then y-1; else y unchanged, enter SCROLL with scroll_dir=1
  - 8 TAB: t = next multiple of TAB_STOP strictly above x. If t <= COLS-1 then x=t, else x = min(x+1, COLS-1).
  - 9 DIRECT: if arg_row < ROWS then y=arg_row, else y unchanged. If arg_col < COLS then x=arg_col, else x unchanged. Each axis is checked independently.
  - 10–15 reserved: accepted and consumed; no position change, no wen.
- Every accepted non-reserved command produces exactly one wen pulse. This includes commands that do not change the position, such as LF at the bottom row or LEFT at column 0.
- SCROLL: cmd_ready=0, scroll_req=1, scroll_dir held stable. On the edge where scroll_ack=1, return to IDLE.
- scroll_ack is ignored in IDLE.
- Reset (asynchronous, any state, including mid-SCROLL):
  - state=IDLE
  - new_x=0, new_y=0
  - wen=0, scroll_req=0, scroll_dir=0
  - cmd_ready=1 immediately after reset deasserts

## Timing
- Command accepted at edge T:
  - new_x/new_y hold the updated position from T+1.
  - wen=1 for exactly the cycle following T, then 0.
- Throughput is one command per cycle in IDLE. Back-to-back commands chain off the updated shadow position with no bubble.
- LF/RLF scroll case: scroll_req and scroll_dir go high from T+1, together with wen, and cmd_ready goes low from T+1. If scroll_ack is sampled high at edge S, scroll_req=0 and cmd_ready=1 from S+1; the earliest next acceptance is edge S+1.
- Minimum scroll round trip is two cycles: scroll_ack high in the first SCROLL cycle.
- new_x/new_y are stable whenever wen=0.

## Test plan
- Reset, then RIGHT ×3 on consecutive cycles -> wen pulses on 3 consecutive cycles; new_x = 1, 2, 3; new_y = 0.
- Saturation:
  - LEFT at x=0 -> x stays 0, wen pulses.
  - DIRECT(23,79), then RIGHT, then DOWN -> x=79, y=23 unchanged, 2 wen pulses.
- TAB:
  - from x=0 -> 8; from x=7 -> 8; from x=8 -> 16.
  - from x=72 -> 73; from x=79 -> 79.
- DIRECT range checks:
  - DIRECT(30,10) from (5,5) -> y=5, x=10.
  - DIRECT(3,100) -> y=3, x=10.
  - cmd 12 -> no wen, position unchanged, cmd_ready stays 1.
- Scroll up: at y=23, LF -> scroll_req=1, scroll_dir=0, y=23, cmd_ready=0 with cmd_valid held. scroll_ack after 5 cycles -> scroll_req drops next cycle and the held command is accepted that edge. Repeat with RLF at y=0 -> scroll_dir=1.
- Assert reset mid-SCROLL, and reset mid-sequence at (40,12) -> outputs go immediately to scroll_req=0, new_x=0, new_y=0, cmd_ready=1. A stray scroll_ack in IDLE has no effect.
